// File: rtl/pc_sequencer.sv
// Program-counter unit for the MIPS fetch stage: registered PC, next-PC selection
// (sequential, branch, jump, jump-register, exception) and a circular return-address stack.
module pc_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] EXC_VEC   = 'h80,
   parameter int                RAS_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           stall,
   input  logic [31:0]                    instr,
   input  logic                           branch,
   input  logic                           branch_ne,
   input  logic                           zero,
   input  logic                           jump,
   input  logic                           link,
   input  logic                           jump_reg,
   input  logic                           ret,
   input  logic [ADDR_W-1:0]              rs_val,
   input  logic                           exc,
   output logic [ADDR_W-1:0]              pc,
   output logic [ADDR_W-1:0]              pc_plus4,
   output logic                           misalign_err,
   output logic                           ras_underflow,
   output logic [$clog2(RAS_DEPTH):0]     ras_count
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0]  r_wr;
   logic [CNT_W-1:0]  r_count;
   logic              r_misalign;
   logic              r_underflow;

   logic [ADDR_W-1:0] w_pc_plus4;
   logic [ADDR_W-1:0] w_br_off;
   logic [ADDR_W-1:0] w_branch_tgt;
   logic [ADDR_W-1:0] w_jump_tgt;
   logic [ADDR_W-1:0] w_jr_tgt;
   logic [ADDR_W-1:0] w_next_pc;
   logic [PTR_W-1:0]  w_top_idx;
   logic              w_push;
   logic              w_pop;
   logic              w_misalign;
   logic              w_underflow;
   logic              w_unused;

   assign w_pc_plus4   = r_pc + ADDR_W'(4);
   assign w_br_off     = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
   assign w_branch_tgt = w_pc_plus4 + w_br_off;
   assign w_jump_tgt   = {w_pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
   // r_wr points at the next free slot, so the top entry sits one below it (wrapping).
   assign w_top_idx    = r_wr - PTR_W'(1);
   assign w_unused     = &{1'b0, instr[31:26]};

   always_comb begin
      w_next_pc   = w_pc_plus4;
      w_jr_tgt    = rs_val;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_misalign  = 1'b0;
      w_underflow = 1'b0;
      if (exc) begin
         w_next_pc = EXC_VEC;
      end else if (stall) begin
         w_next_pc = r_pc;
      end else if (jump_reg) begin
         if (ret && (r_count != '0)) begin
            w_jr_tgt = r_ras[w_top_idx];
            w_pop    = 1'b1;
         end else if (ret) begin
            w_underflow = 1'b1;
         end
         if (w_jr_tgt[1:0] != 2'b00) begin
            w_next_pc  = EXC_VEC;
            w_misalign = 1'b1;
         end else begin
            w_next_pc = w_jr_tgt;
         end
      end else if (jump) begin
         w_next_pc = w_jump_tgt;
         w_push    = link;
      end else if (branch && (zero ^ branch_ne)) begin
         w_next_pc = w_branch_tgt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_VEC;
         r_wr        <= '0;
         r_count     <= '0;
         r_misalign  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_pc        <= w_next_pc;
         r_misalign  <= w_misalign;
         r_underflow <= w_underflow;
         if (w_push) begin
            r_wr <= r_wr + PTR_W'(1);
            if (r_count != CNT_W'(RAS_DEPTH)) begin
               r_count <= r_count + CNT_W'(1);
            end
         end else if (w_pop) begin
            r_wr    <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Stack contents need no reset: r_count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ras[r_wr] <= w_pc_plus4;
      end
   end

   assign pc            = r_pc;
   assign pc_plus4      = w_pc_plus4;
   assign misalign_err  = r_misalign;
   assign ras_underflow = r_underflow;
   assign ras_count     = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (ADDR_W=32, RAS_DEPTH=4).
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic [31:0] instr;
   logic        branch;
   logic        branch_ne;
   logic        zero;
   logic        jump;
   logic        link;
   logic        jump_reg;
   logic        ret;
   logic [31:0] rs_val;
   logic        exc;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misalign_err;
   logic        ras_underflow;
   logic [2:0]  ras_count;

   int nChecks = 0;
   int nFails  = 0;

   logic [31:0] expPc;
   logic [31:0] pushVals [5];

   pc_sequencer #(
      .ADDR_W   (32),
      .RESET_VEC(32'h0000_0000),
      .EXC_VEC  (32'h0000_0080),
      .RAS_DEPTH(4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .instr        (instr),
      .branch       (branch),
      .branch_ne    (branch_ne),
      .zero         (zero),
      .jump         (jump),
      .link         (link),
      .jump_reg     (jump_reg),
      .ret          (ret),
      .rs_val       (rs_val),
      .exc          (exc),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .misalign_err (misalign_err),
      .ras_underflow(ras_underflow),
      .ras_count    (ras_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearInputs();
      stall = 0; instr = '0; branch = 0; branch_ne = 0; zero = 0;
      jump = 0; link = 0; jump_reg = 0; ret = 0; rs_val = '0; exc = 0;
   endtask

   // Inputs are set by the caller; clock once, sample 1 time unit after the edge, then clear.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   task automatic doJump(input logic [25:0] t26, input logic lnk);
      jump = 1; link = lnk; instr = {6'd0, t26};
      applyStimulus();
   endtask

   task automatic doJr(input logic [31:0] rs, input logic r);
      jump_reg = 1; ret = r; rs_val = rs;
      applyStimulus();
   endtask

   task automatic doBranch(input logic ne, input logic z, input logic [15:0] imm);
      branch = 1; branch_ne = ne; zero = z; instr = {16'd0, imm};
      applyStimulus();
   endtask

   initial begin
      clearInputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_pc", pc, 32'h0);
      checkOutput("reset_cnt", ras_count, 3'd0);
      checkOutput("reset_flags", {misalign_err, ras_underflow}, 2'b00);
      @(negedge clk);
      rst_n = 1;
      for (int i = 1; i <= 3; i++) begin
         applyStimulus();
         checkOutput("idle_pc", pc, 32'(i * 4));
      end

      // JAL to 0x40 so both pc and RAS are non-zero before the async reset
      doJump(26'h10, 1);
      checkOutput("jal_pc_40", pc, 32'h40);
      checkOutput("jal_cnt_1", ras_count, 3'd1);
      #2;
      rst_n = 0;
      #1;
      checkOutput("async_rst_pc", pc, 32'h0);
      checkOutput("async_rst_cnt", ras_count, 3'd0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 1; i <= 3; i++) begin
         applyStimulus();
         checkOutput("post_rst_pc", pc, 32'(i * 4));
      end

      // Branches
      doJump(26'h40, 0);
      checkOutput("j_100", pc, 32'h100);
      doBranch(0, 1, 16'hFFFE);
      checkOutput("beq_taken_back", pc, 32'hFC);
      doBranch(1, 1, 16'h0003);
      checkOutput("bne_not_taken", pc, 32'h100);
      doBranch(1, 0, 16'h0003);
      checkOutput("bne_taken_fwd", pc, 32'h110);
      doBranch(0, 0, 16'h0003);
      checkOutput("beq_not_taken", pc, 32'h114);

      // Jump / link / return
      doJr(32'h1000_0010, 0);
      checkOutput("jr_plain", pc, 32'h1000_0010);
      doJump(26'h40, 0);
      checkOutput("j_region", pc, 32'h1000_0100);
      doJr(32'h1000_0010, 0);
      doJump(26'h40, 1);
      checkOutput("jal_pc", pc, 32'h1000_0100);
      checkOutput("jal_cnt", ras_count, 3'd1);
      doJr(32'h0, 1);
      checkOutput("ret_pc", pc, 32'h1000_0014);
      checkOutput("ret_cnt", ras_count, 3'd0);

      // RAS overflow then drain: five pushes, only the newest four survive
      expPc = 32'h1000_0014;
      for (int i = 0; i < 5; i++) begin
         pushVals[i] = expPc + 32'd4;
         doJump(26'((i + 1) * 32'h100), 1);
         expPc = 32'h1000_0000 | ((i + 1) * 32'h400);
         checkOutput("ras_push_pc", pc, expPc);
      end
      checkOutput("ras_full_cnt", ras_count, 3'd4);
      for (int i = 4; i >= 1; i--) begin
         doJr(32'h2000, 1);
         checkOutput("ras_pop_pc", pc, pushVals[i]);
         checkOutput("ras_pop_cnt", ras_count, 3'(i - 1));
         checkOutput("ras_pop_noflag", ras_underflow, 1'b0);
      end
      doJr(32'h2000, 1);
      checkOutput("underflow_pc", pc, 32'h2000);
      checkOutput("underflow_flag", ras_underflow, 1'b1);
      checkOutput("underflow_cnt", ras_count, 3'd0);
      applyStimulus();
      checkOutput("underflow_pulse_end", ras_underflow, 1'b0);

      // Misaligned JR target
      doJr(32'h202, 0);
      checkOutput("misalign_pc", pc, 32'h80);
      checkOutput("misalign_flag", misalign_err, 1'b1);
      applyStimulus();
      checkOutput("misalign_pulse_end", misalign_err, 1'b0);
      checkOutput("after_misalign_pc", pc, 32'h84);

      // Stall and exception; the pushed 0x88 must survive both
      doJump(26'h30, 1);
      checkOutput("jal_c0", pc, 32'hC0);
      stall = 1;
      doJump(26'h40, 1);
      checkOutput("stall_pc", pc, 32'hC0);
      checkOutput("stall_cnt", ras_count, 3'd1);
      stall = 1; exc = 1;
      applyStimulus();
      checkOutput("stall_exc_pc", pc, 32'h80);
      checkOutput("stall_exc_cnt", ras_count, 3'd1);
      doJr(32'h0, 1);
      checkOutput("ras_held_pc", pc, 32'h88);

      // jump_reg outranks jump when both are asserted
      jump = 1; instr = 32'h10;
      doJr(32'h300, 0);
      checkOutput("prio_jr_over_j", pc, 32'h300);
      checkOutput("prio_no_push", ras_count, 3'd0);

      // Wrap at the top of the address space
      doJr(32'hFFFF_FFFC, 0);
      checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
      applyStimulus();
      checkOutput("wrap_pc", pc, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
